// File: rtl/cs_sched_if.sv
// cs_sched_if: sample inputs and tagged result outputs of the two-channel CS scheduler
interface cs_sched_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] x0;
    logic              x0_valid;
    logic              x0_ready;
    logic [DATA_W-1:0] x1;
    logic              x1_valid;
    logic              x1_ready;
    logic [DATA_W+1:0] y;
    logic              y_valid;
    logic              y_ch;
    modport master (
        output x0, x0_valid, x1, x1_valid,
        input  x0_ready, x1_ready, y, y_valid, y_ch
    );
    modport slave (
        input  x0, x0_valid, x1, x1_valid,
        output x0_ready, x1_ready, y, y_valid, y_ch
    );
endinterface

// File: rtl/cs_sched.sv
// cs_sched: round-robin time-sharing of one serial comparator/selector engine between two sample streams
module cs_sched #(
    parameter int DATA_W = 8
) (
    input logic       clk,
    input logic       reset,
    cs_sched_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SUM    = 2'd1;
    localparam logic [1:0] SEARCH = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]        state;
    logic [DATA_W-1:0] win [2][9];
    logic [3:0]        wp  [2];
    logic [3:0]        cnt [2];
    logic              rr;
    logic              job_ch;
    logic [3:0]        idx;
    logic [11:0]       sum;
    logic [DATA_W-1:0] best;
    logic              gnt0;
    logic              gnt1;
    logic              acc;
    logic              gch;
    logic [DATA_W-1:0] din;
    logic [3:0]        cnt_nx;
    logic [3:0]        wp_nx;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] avg;
    logic [DATA_W-1:0] best_nx;
    logic [12:0]       y_full;

    // grant, window-update and engine datapath; ready is held off during reset so no sample is lost
    always_comb begin
        gnt0    = !reset && state == IDLE && bus.x0_valid && (!bus.x1_valid || !rr);
        gnt1    = !reset && state == IDLE && bus.x1_valid && (!bus.x0_valid || rr);
        acc     = gnt0 || gnt1;
        gch     = gnt1;
        din     = gnt1 ? bus.x1 : bus.x0;
        cnt_nx  = cnt[gch] == 4'd9 ? 4'd9 : cnt[gch] + 4'd1;
        wp_nx   = wp[gch] == 4'd8 ? 4'd0 : wp[gch] + 4'd1;
        cur     = win[job_ch][idx];
        avg     = DATA_W'(sum / 12'd9);
        best_nx = (cur <= avg && cur > best) ? cur : best;
        y_full  = (13'(sum) + 13'(best_nx) * 13'd9) >> 3;
    end

    assign bus.x0_ready = gnt0;
    assign bus.x1_ready = gnt1;

    // accept samples in IDLE, then accumulate, search and publish one result per job
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                wp[c]  <= '0;
                cnt[c] <= '0;
                for (int i = 0; i < 9; i++) win[c][i] <= '0;
            end
            rr          <= 1'b0;
            job_ch      <= 1'b0;
            state       <= IDLE;
            idx         <= '0;
            sum         <= '0;
            best        <= '0;
            bus.y       <= '0;
            bus.y_valid <= 1'b0;
            bus.y_ch    <= 1'b0;
        end else begin
            bus.y_valid <= 1'b0;
            case (state)
                IDLE: if (acc) begin
                    win[gch][wp[gch]] <= din;
                    wp[gch]           <= wp_nx;
                    cnt[gch]          <= cnt_nx;
                    rr                <= !gch;
                    if (cnt_nx == 4'd9) begin
                        job_ch <= gch;
                        state  <= SUM;
                        idx    <= '0;
                        sum    <= '0;
                    end
                end
                SUM: begin
                    sum <= sum + 12'(cur);
                    idx <= idx == 4'd8 ? 4'd0 : idx + 4'd1;
                    if (idx == 4'd8) begin
                        state <= SEARCH;
                        best  <= '0;
                    end
                end
                SEARCH: begin
                    best <= best_nx;
                    idx  <= idx == 4'd8 ? 4'd0 : idx + 4'd1;
                    if (idx == 4'd8) begin
                        state       <= DONE;
                        bus.y       <= (DATA_W+2)'(y_full);
                        bus.y_ch    <= job_ch;
                        bus.y_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cs_sched.sv
// tb_cs_sched: randomized and directed checking of cs_sched against a queue-based job model
module tb_cs_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cs_sched_if #(.DATA_W(8)) bus();
    cs_sched #(.DATA_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic       rs = 1'b1;
    logic       pv0 = 1'b0;
    logic       pv1 = 1'b0;
    logic [7:0] pd0 = 8'h00;
    logic [7:0] pd1 = 8'h00;
    bit         arb = 1'b0;
    bit         rnd = 1'b0;

    int  w0[$];
    int  w1[$];
    int  m_rr = 0;
    int  m_busy = 0;
    int  m_jy = 0;
    int  m_jch = 0;
    int  m_ly = 0;
    int  m_lch = 0;
    bit  init = 1'b0;

    int         step_n = 0;
    int         res_n = 0;
    int         last_step = 0;
    int         acc_step = 0;
    int         wide = 0;
    int         gnts[$];
    logic [9:0] got_y = '0;
    logic       got_ch = 1'b0;
    logic       prev_yv = 1'b0;

    function automatic int cs_ref(input int w[$]);
        int s = 0;
        int b = 0;
        int a;
        foreach (w[i]) s += w[i];
        a = s / 9;
        foreach (w[i]) if (w[i] <= a && w[i] > b) b = w[i];
        return (s + 9 * b) / 8;
    endfunction

    function automatic int m_grant();
        if (rs || m_busy != 0) return -1;
        if (pv0 && pv1) return m_rr;
        if (pv0) return 0;
        if (pv1) return 1;
        return -1;
    endfunction

    function automatic logic [7:0] rdata();
        int k = $urandom_range(0, 3);
        return k == 0 ? 8'h00 : k == 1 ? 8'hFF : 8'($urandom);
    endfunction

    task automatic expect_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // one clock: drive at negedge, compare against the model, then advance the model across the posedge
    task automatic cycle();
        int g;
        @(negedge clk);
        if (rnd) begin
            rs = ($urandom_range(0, 399) == 0);
            if (!pv0 && $urandom_range(0, 3) != 0) begin pv0 = 1'b1; pd0 = rdata(); end
            if (!pv1 && $urandom_range(0, 3) != 0) begin pv1 = 1'b1; pd1 = rdata(); end
        end
        if (arb) begin
            if (!pv0) begin pv0 = 1'b1; pd0 = 8'($urandom); end
            if (!pv1) begin pv1 = 1'b1; pd1 = 8'($urandom); end
        end
        reset = rs;
        bus.x0 = pd0;
        bus.x0_valid = pv0;
        bus.x1 = pd1;
        bus.x1_valid = pv1;
        #1;
        g = m_grant();
        checks++;
        if ({bus.x0_ready, bus.x1_ready} !== {g == 0, g == 1} ||
            (init && (bus.y_valid !== (m_busy == 1) || bus.y !== 10'(m_ly) || bus.y_ch !== m_lch[0]))) begin
            errors++;
            $display("FAIL model step %0d: ready=%b%b y_valid=%b y=%0d y_ch=%b, expected ready=%b%b y_valid=%b y=%0d y_ch=%0d",
                     step_n, bus.x0_ready, bus.x1_ready, bus.y_valid, bus.y, bus.y_ch,
                     g == 0, g == 1, m_busy == 1, m_ly, m_lch);
        end
        step_n++;
        if (bus.y_valid === 1'b1) begin
            res_n++;
            got_y = bus.y;
            got_ch = bus.y_ch;
            last_step = step_n;
            if (prev_yv) wide++;
        end
        prev_yv = bus.y_valid;
        if (bus.x0_ready === 1'b1) begin gnts.push_back(0); pv0 = 1'b0; acc_step = step_n; end
        if (bus.x1_ready === 1'b1) begin gnts.push_back(1); pv1 = 1'b0; acc_step = step_n; end
        if (rs) begin
            w0.delete();
            w1.delete();
            m_rr = 0;
            m_busy = 0;
            m_ly = 0;
            m_lch = 0;
        end else if (g == 0) begin
            w0.push_back(int'(pd0));
            if (w0.size() > 9) void'(w0.pop_front());
            if (w0.size() == 9) begin m_jy = cs_ref(w0); m_jch = 0; m_busy = 19; end
            m_rr = 1;
        end else if (g == 1) begin
            w1.push_back(int'(pd1));
            if (w1.size() > 9) void'(w1.pop_front());
            if (w1.size() == 9) begin m_jy = cs_ref(w1); m_jch = 1; m_busy = 19; end
            m_rr = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 1) begin m_ly = m_jy; m_lch = m_jch; end
        end
        init = 1'b1;
    endtask

    task automatic send(input int ch, input logic [7:0] d);
        int n = 0;
        if (ch == 0) begin pv0 = 1'b1; pd0 = d; end
        else begin pv1 = 1'b1; pd1 = d; end
        while ((ch == 0 ? pv0 : pv1) && n < 100) begin cycle(); n++; end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL send_timeout ch%0d: not accepted after %0d cycles, expected within 100", ch, n);
        end
    endtask

    task automatic wait_res(input string name);
        int n = 0;
        int r = res_n;
        while (res_n == r && n < 60) begin cycle(); n++; end
        expect_eq({name, "_result_seen"}, res_n - r, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rs = 1'b1;
        idle(2);
        rs = 1'b0;
    endtask

    int q[$];
    int r0;
    int s_acc;

    initial begin
        q = {65, 62, 77, 80, 71, 70, 63, 85, 72};
        expect_eq("ref_spec_vector", cs_ref(q), 160);
        q = {255, 255, 255, 255, 255, 255, 255, 255, 255};
        expect_eq("ref_saturation", cs_ref(q), 573);
        q = {255, 255, 255, 255, 255, 255, 255, 255, 0};
        expect_eq("ref_sat_then_zero", cs_ref(q), 255);

        rs = 1'b1; pv0 = 1'b1; pv1 = 1'b1; pd0 = 8'h11; pd1 = 8'h22;
        idle(2);
        expect_eq("rst_x0_ready", int'(bus.x0_ready), 0);
        expect_eq("rst_x1_ready", int'(bus.x1_ready), 0);
        expect_eq("rst_y", int'(bus.y), 0);
        expect_eq("rst_y_valid", int'(bus.y_valid), 0);
        expect_eq("rst_y_ch", int'(bus.y_ch), 0);

        rs = 1'b0;
        arb = 1'b1;
        gnts.delete();
        r0 = res_n;
        for (int n = 0; n < 300 && gnts.size() < 18; n++) cycle();
        arb = 1'b0;
        pv0 = 1'b0;
        pv1 = 1'b0;
        expect_eq("arb_grant_count", gnts.size(), 18);
        if (gnts.size() == 18) begin
            for (int i = 0; i < 17; i++) expect_eq($sformatf("arb_grant%0d", i), gnts[i], i % 2);
            expect_eq("arb_grant_after_job", gnts[17], 1);
        end
        expect_eq("arb_results_before_ch1", res_n - r0, 1);
        expect_eq("arb_result_ch", int'(got_ch), 0);
        idle(25);

        do_reset();
        q = {65, 62, 77, 80, 71, 70, 63, 85, 72};
        foreach (q[i]) send(0, 8'(q[i]));
        s_acc = acc_step;
        wait_res("single");
        expect_eq("single_y", int'(got_y), 'h0A0);
        expect_eq("single_ch", int'(got_ch), 0);
        expect_eq("single_latency_steps", last_step - s_acc, 19);
        idle(2);

        do_reset();
        repeat (9) send(1, 8'hFF);
        wait_res("sat");
        expect_eq("sat_y", int'(got_y), 'h23D);
        expect_eq("sat_ch", int'(got_ch), 1);
        send(1, 8'h00);
        expect_eq("sat_next_accept_gap", acc_step - last_step, 1);
        wait_res("sat2");
        expect_eq("sat2_y", int'(got_y), 'h0FF);
        expect_eq("sat2_ch", int'(got_ch), 1);
        idle(2);

        do_reset();
        wide = 0;
        repeat (9) send(0, 8'h00);
        wait_res("zero");
        expect_eq("zero_y", int'(got_y), 0);
        cycle();
        expect_eq("zero_pulse_end", int'(bus.y_valid), 0);
        expect_eq("zero_pulse_wide", wide, 0);

        do_reset();
        repeat (9) send(0, 8'($urandom));
        idle(12);
        rs = 1'b1;
        cycle();
        rs = 1'b0;
        r0 = res_n;
        idle(30);
        expect_eq("abort_no_result", res_n - r0, 0);
        repeat (8) send(0, 8'($urandom));
        idle(25);
        expect_eq("abort_refill_no_result", res_n - r0, 0);
        send(0, 8'($urandom));
        wait_res("abort_ninth");

        rnd = 1'b1;
        idle(3000);
        rnd = 1'b0;
        rs = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
